// File: rtl/mir_io_pkg.sv
// Shared types and constants for the IN-instruction UART input path.
package mir_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_e;

    localparam logic [2:0]  UARTC_NORMAL = 3'b000;
    localparam logic [2:0]  UARTC_RX     = 3'b010;
    localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/uart_word_packer.sv
// Packs received UART bytes little-endian into a 32-bit word and tracks the
// byte count; flags the cycle in which the final byte of the word is accepted.
module uart_word_packer
    import mir_io_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    din,
    output logic [31:0]   word,
    output logic          last
);

    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (wr_en) begin
            // Lanes at or above NBYTES are never selected, so they stay zero.
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (cnt_q == 3'(k)) begin
                    word_d[k*BYTE_W +: BYTE_W] = din;
                end
            end
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word = word_q;
    assign last = wr_en && !clr && (cnt_q == 3'(NBYTES - 1));

endmodule

// File: rtl/uart_in_ctrl.sv
// IN-instruction sequencer: stalls the core, collects NBYTES UART bytes and
// steers the write-back mux for one cycle. Optional timeout: UART_IN_TIMEOUT_EN.
module uart_in_ctrl
    import mir_io_pkg::*;
#(
    parameter int unsigned NBYTES      = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_req,
    input  logic        src_sel,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        stall,
    output logic        mux_sinal,
    output logic [2:0]  mux_uartc,
    output logic [31:0] uart_word,
    output logic        rf_we_uart,
    output logic        timeout_err
);

    if (NBYTES < 1 || NBYTES > 4) begin : g_bad_nbytes
        $error("uart_in_ctrl: NBYTES must be in 1..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_in_ctrl: TIMEOUT_CYC must be at least 1");
    end

    state_e state_q, state_d;
    logic   accept;
    logic   start;
    logic   byte_last;
    logic   timeout;

    assign accept = (state_q == COLLECT) && rx_valid;
    assign start  = (state_q == IDLE) && in_req;

`ifdef UART_IN_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    assign timeout = (state_q == COLLECT) && !accept &&
                     (to_cnt_q == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (start || accept) begin
            to_cnt_d = '0;
        end else if (state_q == COLLECT) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
        timeout_err_d = timeout_err_q | timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // A timeout clears the partial word so the write-back carries zero.
    uart_word_packer #(
        .NBYTES (NBYTES)
    ) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start || timeout),
        .wr_en (accept),
        .din   (rx_data),
        .word  (uart_word),
        .last  (byte_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_req) state_d = COLLECT;
            COLLECT: if (byte_last || timeout) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        rx_ready   = 1'b0;
        stall      = 1'b0;
        rf_we_uart = 1'b0;
        mux_sinal  = src_sel;
        mux_uartc  = UARTC_NORMAL;
        case (state_q)
            COLLECT: begin
                stall    = 1'b1;
                rx_ready = 1'b1;
            end
            WRITE: begin
                rf_we_uart = 1'b1;
                mux_sinal  = 1'b0;
                mux_uartc  = UARTC_RX;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_in_ctrl.sv
// Directed self-checking bench for uart_in_ctrl (NBYTES=4 and NBYTES=2 instances).
module tb_uart_in_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_req = 1'b0, src_sel = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready, stall, mux_sinal, rf_we_uart, timeout_err;
    logic [2:0]  mux_uartc;
    logic [31:0] uart_word;

    logic        in_req2 = 1'b0, rx_valid2 = 1'b0;
    logic [7:0]  rx_data2 = '0;
    logic        rx_ready2, stall2, mux_sinal2, rf_we_uart2, timeout_err2;
    logic [2:0]  mux_uartc2;
    logic [31:0] uart_word2;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int cons_cnt = 0;

    always #5 clk = ~clk;

    uart_in_ctrl #(.NBYTES(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .src_sel(src_sel),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .stall(stall), .mux_sinal(mux_sinal), .mux_uartc(mux_uartc),
        .uart_word(uart_word), .rf_we_uart(rf_we_uart), .timeout_err(timeout_err)
    );

    uart_in_ctrl #(.NBYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_req(in_req2), .src_sel(1'b1),
        .rx_valid(rx_valid2), .rx_data(rx_data2), .rx_ready(rx_ready2),
        .stall(stall2), .mux_sinal(mux_sinal2), .mux_uartc(mux_uartc2),
        .uart_word(uart_word2), .rf_we_uart(rf_we_uart2), .timeout_err(timeout_err2)
    );

    always @(negedge clk) begin
        if (rf_we_uart) we_cnt++;
        if (rx_valid && rx_ready) cons_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_req = 1'b0; rx_valid = 1'b0; in_req2 = 1'b0; rx_valid2 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Issues in_req then four back-to-back bytes; returns in the WRITE cycle.
    task automatic send_word(input logic [31:0] w);
        tick(); in_req = 1'b1;
        tick(); in_req = 1'b0; rx_valid = 1'b1; rx_data = w[7:0];
        tick(); rx_data = w[15:8];
        tick(); rx_data = w[23:16];
        tick(); rx_data = w[31:24];
        tick(); rx_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src_sel = 1'b0;
        #3;
        checks++;
        if ({stall, rx_ready, rf_we_uart, timeout_err, mux_uartc, mux_sinal} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {stall, rx_ready, rf_we_uart, timeout_err, mux_uartc, mux_sinal});
        end
        checks++;
        if (uart_word !== 32'h0) begin
            errors++; $display("FAIL reset_word: got %h want 00000000", uart_word);
        end
        src_sel = 1'b1; #1;
        checks++;
        if (mux_sinal !== 1'b1) begin
            errors++; $display("FAIL reset_sinal: got %b want 1", mux_sinal);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 4; i++) begin
            tick(); src_sel = i[0]; rx_valid = 1'b1; rx_data = 8'h3C; #1;
            checks++;
            if ({mux_sinal, mux_uartc, stall, rx_ready} !== {i[0], 3'b000, 2'b00}) begin
                errors++;
                $display("FAIL passthru_%0d: got %b want %b", i,
                         {mux_sinal, mux_uartc, stall, rx_ready}, {i[0], 3'b000, 2'b00});
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int we0, c0;
        we0 = we_cnt; c0 = cons_cnt;
        src_sel = 1'b1;
        tick(); in_req = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE; #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++; $display("FAIL req_and_valid_idle: rx_ready got %b want 0", rx_ready);
        end
        tick(); in_req = 1'b0; rx_data = 8'h78; #1;
        checks++;
        if ({stall, rx_ready} !== 2'b11) begin
            errors++; $display("FAIL collect_ctrl: got %b want 11", {stall, rx_ready});
        end
        tick(); rx_data = 8'h56;
        tick(); rx_data = 8'h34;
        tick(); rx_data = 8'h12;
        tick(); rx_valid = 1'b0; #1;
        checks++;
        if ({rf_we_uart, mux_sinal, mux_uartc, stall, rx_ready} !== 7'b1001000) begin
            errors++;
            $display("FAIL b2b_write_ctrl: got %b want 1001000",
                     {rf_we_uart, mux_sinal, mux_uartc, stall, rx_ready});
        end
        checks++;
        if (uart_word !== 32'h12345678) begin
            errors++; $display("FAIL b2b_word: got %h want 12345678", uart_word);
        end
        tick(); #1;
        checks++;
        if ({rf_we_uart, mux_sinal, mux_uartc, stall} !== 6'b010000) begin
            errors++;
            $display("FAIL b2b_after: got %b want 010000",
                     {rf_we_uart, mux_sinal, mux_uartc, stall});
        end
        checks++;
        if (we_cnt - we0 !== 1 || cons_cnt - c0 !== 4) begin
            errors++;
            $display("FAIL b2b_counts: strobes %0d bytes %0d want 1 4", we_cnt - we0, cons_cnt - c0);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b [4];
        int we0;
        logic stall_dropped;
        b = '{8'h78, 8'h56, 8'h34, 8'h12};
        we0 = we_cnt; stall_dropped = 1'b0;
        tick(); in_req = 1'b1;
        tick(); in_req = 1'b0; rx_valid = 1'b1; rx_data = b[0];
        for (int i = 1; i < 4; i++) begin
            for (int g = 0; g < 5; g++) begin
                tick(); rx_valid = 1'b0; #1;
                if (stall !== 1'b1) stall_dropped = 1'b1;
            end
            tick(); rx_valid = 1'b1; rx_data = b[i];
        end
        tick(); rx_valid = 1'b0; #1;
        checks++;
        if (stall_dropped !== 1'b0) begin
            errors++; $display("FAIL gaps_stall: stall dropped during gap, want held 1");
        end
        checks++;
        if (rf_we_uart !== 1'b1 || uart_word !== 32'h12345678) begin
            errors++;
            $display("FAIL gaps_write: we %b word %h want 1 12345678", rf_we_uart, uart_word);
        end
        tick(); tick(); #1;
        checks++;
        if (we_cnt - we0 !== 1) begin
            errors++; $display("FAIL gaps_pulses: got %0d want 1", we_cnt - we0);
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        we0 = we_cnt;
        tick(); in_req = 1'b1;
        tick(); in_req = 1'b0; rx_valid = 1'b1; rx_data = 8'h11;
        tick(); rx_data = 8'h22;
        tick(); rx_valid = 1'b0; #1;
        rst_n = 1'b0; #1;
        checks++;
        if ({stall, rx_ready, rf_we_uart} !== 3'b000 || uart_word !== 32'h0) begin
            errors++;
            $display("FAIL midreset: ctrl %b word %h want 000 00000000",
                     {stall, rx_ready, rf_we_uart}, uart_word);
        end
        tick(); tick();
        rst_n = 1'b1;
        checks++;
        if (we_cnt !== we0) begin
            errors++; $display("FAIL midreset_strobe: got %0d strobes want 0", we_cnt - we0);
        end
        send_word(32'hDDCCBBAA);
        checks++;
        if (rf_we_uart !== 1'b1 || uart_word !== 32'hDDCCBBAA) begin
            errors++;
            $display("FAIL midreset_new: we %b word %h want 1 ddccbbaa", rf_we_uart, uart_word);
        end
    endtask

    task automatic test_ignored_req();
        int we0, c0;
        logic idle_bad;
        tick(); tick();
        we0 = we_cnt; c0 = cons_cnt; idle_bad = 1'b0;
        tick(); in_req = 1'b1;
        tick(); in_req = 1'b0; rx_valid = 1'b1; rx_data = 8'h01;
        tick(); in_req = 1'b1; rx_data = 8'h02;
        tick(); in_req = 1'b0; rx_data = 8'h03;
        tick(); rx_data = 8'h04;
        tick(); rx_data = 8'h99; #1;
        checks++;
        if (rf_we_uart !== 1'b1 || uart_word !== 32'h04030201 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignreq_write: we %b word %h rdy %b want 1 04030201 0",
                     rf_we_uart, uart_word, rx_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            if (rx_ready !== 1'b0 || stall !== 1'b0) idle_bad = 1'b1;
        end
        rx_valid = 1'b0;
        checks++;
        if (idle_bad !== 1'b0) begin
            errors++; $display("FAIL ignreq_idle: rx_ready/stall asserted in IDLE, want 0");
        end
        checks++;
        if (we_cnt - we0 !== 1 || cons_cnt - c0 !== 4) begin
            errors++;
            $display("FAIL ignreq_counts: strobes %0d bytes %0d want 1 4", we_cnt - we0, cons_cnt - c0);
        end
    endtask

    task automatic test_nbytes2();
        tick(); in_req2 = 1'b1;
        tick(); in_req2 = 1'b0; rx_valid2 = 1'b1; rx_data2 = 8'h11; #1;
        checks++;
        if ({stall2, rx_ready2} !== 2'b11) begin
            errors++; $display("FAIL nb2_collect: got %b want 11", {stall2, rx_ready2});
        end
        tick(); rx_data2 = 8'h22;
        tick(); rx_valid2 = 1'b0; #1;
        checks++;
        if ({rf_we_uart2, mux_sinal2, mux_uartc2} !== 5'b10010 || uart_word2 !== 32'h00002211) begin
            errors++;
            $display("FAIL nb2_write: ctrl %b word %h want 10010 00002211",
                     {rf_we_uart2, mux_sinal2, mux_uartc2}, uart_word2);
        end
        tick(); #1;
        checks++;
        if ({rf_we_uart2, mux_sinal2, timeout_err2} !== 3'b010) begin
            errors++;
            $display("FAIL nb2_after: got %b want 010", {rf_we_uart2, mux_sinal2, timeout_err2});
        end
    endtask

`ifdef UART_IN_TIMEOUT_EN
    task automatic test_timeout();
        int seen_at;
        seen_at = -1;
        do_reset();
        tick(); in_req = 1'b1;
        tick(); in_req = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A;
        tick(); rx_valid = 1'b0; #1;
        for (int c = 2; c < 40 && seen_at < 0; c++) begin
            if (rf_we_uart === 1'b1) begin
                seen_at = c;
                checks++;
                if (uart_word !== 32'h0 || timeout_err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_write: word %h err %b want 00000000 1", uart_word, timeout_err);
                end
            end else begin
                tick(); #1;
            end
        end
        checks++;
        if (seen_at !== 18) begin
            errors++; $display("FAIL timeout_cycle: got %0d want 18", seen_at);
        end
        for (int i = 0; i < 5; i++) tick();
        #1;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_reset: got %b want 0", timeout_err);
        end
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_ignored_req();
        test_nbytes2();
`ifdef UART_IN_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
